subbytes_seq_ctrl: RTL
======================

Name: subbytes_seq_ctrl

Overview:
- Iterative controller that runs one 128-bit AES SubBytes operation through a narrow shared S-box bank of LANES byte-wide Sboxes instead of 16 parallel instances.
- Accepts a state word via valid/ready, slices it into 16/LANES chunks, drives one chunk per cycle to the external Sbox bank, and reassembles the substituted state.
- Presents the result via valid/ready. Sits between the round-key/ShiftRows datapath and the area-reduced Sbox bank.

Parameters:
- BYTE, 8, bits per byte.
- LENGTH, 128, state width in bits.
- LANES, 4, Sbox instances in the shared bank (bytes per cycle). Legal values: 1, 2, 4, 8, 16.
- CNT_W, 4, width of the chunk counter. Must satisfy 2^CNT_W >= LENGTH/(LANES*BYTE).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input state valid
- in_ready  output  1  controller can accept a state
- in_data  input  LENGTH  state to substitute
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  LENGTH  substituted state
- sbox_in  output  LANES*BYTE  bytes presented to the shared Sbox bank
- sbox_out  input  LANES*BYTE  combinational Sbox bank result for sbox_in
- busy  output  1  high while in BUSY state
- chunk_idx  output  CNT_W  chunk currently being substituted

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low (rst_n).
  - Reset values: FSM=IDLE, cnt=0, state_reg=0, result_reg=0, out_valid=0, busy=0, chunk_idx=0, sbox_in=0.
  - in_ready follows the FSM, so it reads 1 during and after reset.
- Definitions:
  - N = LENGTH/(LANES*BYTE).
  - Chunk k = bits [(k+1)*LANES*BYTE-1 : k*LANES*BYTE]. Chunk 0 (LSB) is processed first.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into state_reg, set cnt=0, go to BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - sbox_in = chunk cnt of state_reg. This is combinational from registers; the Sbox bank is combinational, so the full path is reg -> sbox -> reg in one cycle.
  - Each edge: write sbox_out into result_reg chunk cnt.
  - If cnt==N-1, go to DONE. Otherwise cnt++.
  - chunk_idx = cnt.
- DONE:
  - out_valid=1, out_data=result_reg, held stable until out_ready.
  - out_ready=1 with in_valid=0: go to IDLE, out_valid drops next cycle.
  - out_ready=1 with in_valid=1: back-to-back accept. Latch the new state, cnt=0, go to BUSY.
  - in_ready = out_ready while in DONE (combinational).
- Latency: N cycles from the accepting edge to the edge that raises out_valid (4 for defaults).
  - Throughput: one state per N+1 cycles when the sink is always ready.
- Outside BUSY: sbox_in = 0 (quiet bus), chunk_idx = 0.
- out_data:
  - Before the first completion it reads 0.
  - After out_valid falls it holds its last value until overwritten; it is valid only when out_valid=1.
- in_data is sampled only on the accepting edge; changes to it during BUSY have no effect.
- LANES=16 (N=1): BUSY lasts exactly one cycle, and cnt stays 0.
- rst_n low mid-BUSY or mid-DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse is produced.
- out_ready while not in DONE is ignored. in_valid while in BUSY is ignored; the upstream holds it until in_ready.

Test Plan:
- Basic: in_data=128'h000102030405060708090A0B0C0D0E0F with a real Sbox model on the sbox ports -> after 4 cycles out_valid=1, out_data=128'h637C777BF26B6FC53001672BFED7AB76; busy high for exactly 4 cycles; chunk_idx sequence 0,1,2,3.
- Backpressure: same input with out_ready=0 for 10 cycles -> out_valid and out_data held stable and in_ready=0; raising out_ready completes the transfer in one cycle.
- Back-to-back: out_ready tied 1 and in_valid held with states 128'h00..00 then 128'hFF..FF -> outputs 128'h6363...63 then 128'h1616...16; second accept occurs on the same edge as the first output transfer.
- Reset mid-op: assert rst_n=0 at chunk_idx=2 -> asynchronously out_valid=0, busy=0, in_ready=1; a subsequent new input (all 8'h53) yields 128'hEDED...ED.
- Parameter sweep: LANES=1 (16 cycles) and LANES=16 (1 cycle) on 128'h000102...0F -> the same result as the basic case; latency equals N.
- Input stability: change in_data during BUSY -> result reflects only the value latched at accept.

Source files
------------

// File: rtl/subbytes_seq_ctrl.sv
// -----------------------------------------------------------------------------
// subbytes_seq_ctrl
// Iterative AES SubBytes controller. A 128-bit state is accepted on a
// valid/ready handshake, sliced into LENGTH/(LANES*BYTE) chunks, and pushed one
// chunk per cycle through an external, combinational, LANES-wide Sbox bank.
// The substituted chunks are reassembled and presented on a valid/ready
// output. Chunk 0 (least significant bits) is processed first.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input state valid
//   in_ready   controller can accept a state (combinational from FSM/out_ready)
//   in_data    state to substitute, sampled only on the accepting edge
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   out_data   substituted state, meaningful only while out_valid is high
//   sbox_in    chunk presented to the shared Sbox bank (zero outside BUSY)
//   sbox_out   combinational Sbox bank result for sbox_in
//   busy       high while substituting
//   chunk_idx  chunk currently being substituted (zero outside BUSY)
// -----------------------------------------------------------------------------
module subbytes_seq_ctrl #(
  parameter int unsigned BYTE   = 8,
  parameter int unsigned LENGTH = 128,
  parameter int unsigned LANES  = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LENGTH-1:0]       in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LENGTH-1:0]       out_data,
  output logic [LANES*BYTE-1:0]   sbox_in,
  input  logic [LANES*BYTE-1:0]   sbox_out,
  output logic                    busy,
  output logic [CNT_W-1:0]        chunk_idx
);

  localparam int unsigned CHUNK_W = LANES * BYTE;
  localparam int unsigned N_CHUNK = LENGTH / CHUNK_W;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N_CHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LENGTH-1:0]   state_reg_q, state_reg_d;
  logic [LENGTH-1:0]   result_q, result_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      state_reg_q <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      state_reg_q <= state_reg_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, datapath update and handshake decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    state_reg_d = state_reg_q;
    result_d    = result_q;
    in_ready    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_reg_d = in_data;
          cnt_d       = '0;
          state_d     = S_BUSY;
        end
      end

      S_BUSY: begin
        for (int unsigned k = 0; k < N_CHUNK; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            result_d[k*CHUNK_W +: CHUNK_W] = sbox_out;
          end
        end
        // The counter is parked at zero on leaving so chunk_idx reads 0 outside BUSY.
        if (cnt_q == LAST_CHUNK) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        // A pending input may be accepted on the same edge the result leaves.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            state_reg_d = in_data;
            cnt_d       = '0;
            state_d     = S_BUSY;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d      = (state_d == S_BUSY);
    out_valid_d = (state_d == S_DONE);
  end

  // Chunk select toward the Sbox bank; bus is held quiet outside BUSY
  always_comb begin
    sbox_in = '0;
    if (busy_q) begin
      for (int unsigned k = 0; k < N_CHUNK; k++) begin
        if (cnt_q == CNT_W'(k)) begin
          sbox_in = state_reg_q[k*CHUNK_W +: CHUNK_W];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = result_q;
  assign busy      = busy_q;
  assign chunk_idx = cnt_q;

endmodule
